// File: rtl/mul_16bit_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Signed operation is selected by defining MUL_16BIT_SIGNED_EN.
package mul_16bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 16;
  localparam int CNT_W         = 5;
  localparam int ITER          = 16;

endpackage

// File: rtl/mul_16bit_if.sv
// Request/response bundle between a multiply requester and mul_16bit.
interface mul_16bit_if
  import mul_16bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;

  modport master (output start, A, B, input result, busy, done);
  modport slave  (input start, A, B, output result, busy, done);

endinterface

// File: rtl/mul_16bit_negate.sv
// Combinational conditional two's-complement negator, used by the signed build.
module mul_16bit_negate #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] out
);

  assign out = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mul_16bit.sv
// Sequential shift-add multiplier: one multiplier bit per CALC cycle, fixed latency.
// Define MUL_16BIT_SIGNED_EN to treat A/B as two's complement (sign-magnitude around the core).
module mul_16bit
  import mul_16bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic        clk,
  input logic        reset,
  mul_16bit_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW:0]      acc;
  logic [PW:0]      acc_step;
  logic [WIDTH:0]   upper_sum;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    result_reg;
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic             last_step;
  logic             busy;
  logic             done;

  // Partial sums enter the top WIDTH+1 bits, then the whole accumulator shifts right.
  assign upper_sum = acc[PW:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_step  = {upper_sum, acc[WIDTH-1:0]} >> 1;
  assign last_step = (cnt == CNT_W'(ITER - 1));

`ifdef MUL_16BIT_SIGNED_EN
  logic          sign;
  logic [PW-1:0] product_mag;

  mul_16bit_negate #(.WIDTH(WIDTH)) u_neg_a (
    .value (bus.A),
    .negate(bus.A[WIDTH-1]),
    .out   (load_a)
  );

  mul_16bit_negate #(.WIDTH(WIDTH)) u_neg_b (
    .value (bus.B),
    .negate(bus.B[WIDTH-1]),
    .out   (load_b)
  );

  assign product_mag = acc_step[PW-1:0];

  mul_16bit_negate #(.WIDTH(PW)) u_neg_p (
    .value (product_mag),
    .negate(sign),
    .out   (product)
  );
`else
  assign load_a  = bus.A;
  assign load_b  = bus.B;
  assign product = acc_step[PW-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final product is captured on the same edge that leaves CALC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      result_reg <= '0;
`ifdef MUL_16BIT_SIGNED_EN
      sign       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mcand      <= load_a;
          mplier     <= load_b;
          acc        <= '0;
          cnt        <= '0;
          result_reg <= '0;
`ifdef MUL_16BIT_SIGNED_EN
          sign       <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
`endif
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) result_reg <= product;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_reg;
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule
